// File: rtl/mac_accumulator_if.sv
// Valid/ready bundle for mac_accumulator: product beats in, group results out.
// The slave modport is the accumulator; the master modport is whoever drives it.
interface mac_accumulator_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned COUNT = 4
);
  localparam int unsigned AccW = 2 * N + $clog2(COUNT);
  localparam int unsigned CntW = $clog2(COUNT + 1);

  logic            i_valid;
  logic            o_ready;
  logic [2*N-1:0]  i_p;
  logic            i_last;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [AccW-1:0] o_sum;
  logic [CntW-1:0] o_count;

  modport slave (
    input  i_valid, i_p, i_last, i_flush, i_ready,
    output o_ready, o_valid, o_sum, o_count
  );

  modport master (
    output i_valid, i_p, i_last, i_flush, i_ready,
    input  o_ready, o_valid, o_sum, o_count
  );
endinterface

// File: rtl/mac_accumulator.sv
// Sums groups of up to COUNT unsigned products and presents each group sum
// on a valid/ready result port; one bubble cycle separates groups.
module mac_accumulator #(
  parameter int unsigned N     = 4,
  parameter int unsigned COUNT = 4
) (
  input logic          i_clk,
  input logic          i_reset_n,
  mac_accumulator_if.slave bus
);
  localparam int unsigned AccW = 2 * N + $clog2(COUNT);
  localparam int unsigned CntW = $clog2(COUNT + 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] sum_q, sum_d;
  logic [CntW-1:0] count_q, count_d;

  logic [AccW-1:0] acc_plus_p;
  logic            closes;

  assign acc_plus_p = acc_q + AccW'(bus.i_p);
  // A beat closes the group on i_last or when it would be the COUNT-th beat.
  assign closes     = bus.i_last || (cnt_q == CntW'(COUNT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    count_d = count_q;
    case (state_q)
      StAccum: begin
        // Flush takes priority over a beat presented in the same cycle.
        if (bus.i_flush) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (bus.i_valid) begin
          if (closes) begin
            sum_d   = acc_plus_p;
            count_d = cnt_q + CntW'(1);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            acc_d = acc_plus_p;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (bus.i_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // Handshake outputs depend on state only, never combinationally on inputs.
  assign bus.o_ready = (state_q == StAccum);
  assign bus.o_valid = (state_q == StHold);
  assign bus.o_sum   = sum_q;
  assign bus.o_count = count_q;
endmodule
